exception_unit: RTL and testbench

- Drives the program counter's enable and next-address inputs.
- Detects synchronous faults and latched external interrupts, and forces the PC to the exception vector 0x0000 by deasserting pc_en.
- Records the return address (EPC) and cause, and steers the PC back to EPC on return-from-exception.
- Sits between next-PC/branch logic, decode/ALU fault outputs and the program counter.

---
 rtl/exception_unit.sv | 167 ++++++++++++++++
 tb/tb_exception_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_unit.sv
// Exception/interrupt controller in front of the program counter: detects faults and
// latched interrupts, vectors the PC to 0x0000, and returns to the saved EPC on eret.
module exception_unit #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic [ADDR_W-1:0] pc_seq,
  input  logic              err_imisalign,
  input  logic              err_illegal,
  input  logic              err_ovf,
  input  logic              err_dmisalign,
  input  logic              eret,
  input  logic              ext_irq,
  output logic              pc_en,
  output logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] epc,
  output logic [3:0]        cause,
  output logic              in_exc,
  output logic              irq_ack,
  output logic [CNT_W-1:0]  exc_count
);

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } state_t;

  localparam logic [3:0] CAUSE_NONE   = 4'd0;
  localparam logic [3:0] CAUSE_IMIS   = 4'd1;
  localparam logic [3:0] CAUSE_ILL    = 4'd2;
  localparam logic [3:0] CAUSE_OVF    = 4'd3;
  localparam logic [3:0] CAUSE_DMIS   = 4'd4;
  localparam logic [3:0] CAUSE_IRQ    = 4'd5;
  localparam logic [3:0] CAUSE_DOUBLE = 4'd7;

  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

  // Fixed-priority encoder for synchronous faults; CAUSE_NONE means no fault.
  function automatic logic [3:0] fault_code(input logic imis, input logic ill,
                                            input logic ovf, input logic dmis);
    logic [3:0] code;
    code = CAUSE_NONE;
    if (imis) begin
      code = CAUSE_IMIS;
    end else if (ill) begin
      code = CAUSE_ILL;
    end else if (ovf) begin
      code = CAUSE_OVF;
    end else if (dmis) begin
      code = CAUSE_DMIS;
    end else begin
      code = CAUSE_NONE;
    end
    return code;
  endfunction

  state_t             state_q;
  logic [ADDR_W-1:0]  epc_q;
  logic [3:0]         cause_q;
  logic               in_exc_q;
  logic               irq_ack_q;
  logic [CNT_W-1:0]   exc_count_q;
  logic [CNT_W-1:0]   exc_count_d;
  logic               irq_pending_q;
  logic               irq_prev_q;

  logic               is_normal;
  logic               irq_edge;
  logic               irq_seen;
  logic               ill_eff;
  logic [3:0]         code;
  logic               fault;
  logic               take_irq;
  logic               take;
  logic               do_return;

  // Fault/interrupt decision and the PC steering driven in the same cycle.
  always_comb begin
    is_normal = (state_q == ST_NORMAL);
    irq_edge  = ext_irq & ~irq_prev_q;
    // A rising edge seen this cycle counts as pending immediately.
    irq_seen  = irq_pending_q | irq_edge;
    ill_eff   = err_illegal | (eret & is_normal);
    code      = fault_code(err_imisalign, ill_eff, err_ovf, err_dmisalign);
    fault     = (code != CAUSE_NONE);
    take_irq  = is_normal & irq_seen & ~fault;
    take      = fault | take_irq;
    do_return = ~is_normal & eret & ~fault;
    pc_en     = ~take;
    if (do_return) begin
      pc_in = epc_q;
    end else begin
      pc_in = pc_seq;
    end
    if (take && !(&exc_count_q)) begin
      exc_count_d = exc_count_q + CNT_ONE;
    end else begin
      exc_count_d = exc_count_q;
    end
  end

  // Handler state machine with registered status outputs and interrupt latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_NORMAL;
      epc_q         <= ADDR_ZERO;
      cause_q       <= CAUSE_NONE;
      in_exc_q      <= 1'b0;
      irq_ack_q     <= 1'b0;
      exc_count_q   <= CNT_ZERO;
      irq_pending_q <= 1'b0;
      irq_prev_q    <= 1'b0;
    end else begin
      irq_prev_q  <= ext_irq;
      irq_ack_q   <= take_irq;
      exc_count_q <= exc_count_d;
      case (state_q)
        ST_NORMAL: begin
          if (fault) begin
            state_q       <= ST_HANDLER;
            in_exc_q      <= 1'b1;
            cause_q       <= code;
            epc_q         <= pc_cur;
            irq_pending_q <= irq_seen;
          end else if (take_irq) begin
            // Resume after the interrupted instruction, hence pc_seq.
            state_q       <= ST_HANDLER;
            in_exc_q      <= 1'b1;
            cause_q       <= CAUSE_IRQ;
            epc_q         <= pc_seq;
            irq_pending_q <= 1'b0;
          end else begin
            irq_pending_q <= irq_seen;
          end
        end
        ST_HANDLER: begin
          irq_pending_q <= irq_seen;
          if (fault) begin
            cause_q <= CAUSE_DOUBLE;
          end else if (do_return) begin
            state_q  <= ST_NORMAL;
            in_exc_q <= 1'b0;
          end else begin
            state_q <= ST_HANDLER;
          end
        end
        default: begin
          state_q       <= ST_NORMAL;
          in_exc_q      <= 1'b0;
          irq_pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign epc       = epc_q;
  assign cause     = cause_q;
  assign in_exc    = in_exc_q;
  assign irq_ack   = irq_ack_q;
  assign exc_count = exc_count_q;

endmodule

// File: tb/tb_exception_unit.sv
// Scoreboard bench for exception_unit: a cycle model queues expected outputs at drive
// time; they are popped and compared once the DUT has produced them.
module tb_exception_unit;

  logic        clk;
  logic        rst;
  logic [15:0] pc_cur;
  logic [15:0] pc_seq;
  logic        err_imisalign;
  logic        err_illegal;
  logic        err_ovf;
  logic        err_dmisalign;
  logic        eret;
  logic        ext_irq;
  logic        pc_en;
  logic [15:0] pc_in;
  logic [15:0] epc;
  logic [3:0]  cause;
  logic        in_exc;
  logic        irq_ack;
  logic [7:0]  exc_count;

  exception_unit #(.ADDR_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_seq(pc_seq),
    .err_imisalign(err_imisalign), .err_illegal(err_illegal), .err_ovf(err_ovf),
    .err_dmisalign(err_dmisalign), .eret(eret), .ext_irq(ext_irq),
    .pc_en(pc_en), .pc_in(pc_in), .epc(epc), .cause(cause), .in_exc(in_exc),
    .irq_ack(irq_ack), .exc_count(exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pc_en;
    logic [15:0] pc_in;
  } comb_exp_t;

  typedef struct {
    logic [15:0] epc;
    logic [3:0]  cause;
    logic        in_exc;
    logic        irq_ack;
    logic [7:0]  cnt;
  } reg_exp_t;

  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];

  int vectors = 0;
  int miscompares = 0;

  // reference state
  bit          m_handler;
  logic [15:0] m_epc;
  logic [3:0]  m_cause;
  bit          m_ack;
  int          m_cnt;
  bit          m_pend;
  bit          m_prev;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_handler = 1'b0;
    m_epc     = 16'h0000;
    m_cause   = 4'd0;
    m_ack     = 1'b0;
    m_cnt     = 0;
    m_pend    = 1'b0;
    m_prev    = 1'b0;
  endtask

  // Evaluate one cycle of the intended behaviour on the currently driven inputs.
  task automatic model_step();
    comb_exp_t ce;
    reg_exp_t  re;
    bit        pend;
    int        code;
    bit        fault;
    bit        irq_take;
    bit        take;
    pend = m_pend || (ext_irq && !m_prev);
    if (err_imisalign)                         code = 1;
    else if (err_illegal || (!m_handler && eret)) code = 2;
    else if (err_ovf)                          code = 3;
    else if (err_dmisalign)                    code = 4;
    else                                       code = 0;
    fault    = (code != 0);
    irq_take = !m_handler && pend && !fault;
    take     = fault || irq_take;
    ce.pc_en = !take;
    ce.pc_in = (m_handler && eret && !fault) ? m_epc : pc_seq;
    comb_q.push_back(ce);

    m_prev = ext_irq;
    m_ack  = irq_take;
    if (take && m_cnt < 255) m_cnt = m_cnt + 1;
    if (!m_handler) begin
      if (fault) begin
        m_handler = 1'b1; m_cause = 4'(code); m_epc = pc_cur;
      end else if (irq_take) begin
        m_handler = 1'b1; m_cause = 4'd5; m_epc = pc_seq; pend = 1'b0;
      end
    end else begin
      if (fault) m_cause = 4'd7;
      else if (eret) m_handler = 1'b0;
    end
    m_pend = pend;

    re.epc = m_epc; re.cause = m_cause; re.in_exc = m_handler;
    re.irq_ack = m_ack; re.cnt = 8'(m_cnt);
    reg_q.push_back(re);
  endtask

  task automatic cycle(input logic [15:0] cur, input logic [15:0] seq,
                       input logic imis, input logic ill, input logic ovf,
                       input logic dmis, input logic er, input logic irq);
    comb_exp_t ce;
    reg_exp_t  re;
    @(negedge clk);
    pc_cur = cur; pc_seq = seq;
    err_imisalign = imis; err_illegal = ill; err_ovf = ovf; err_dmisalign = dmis;
    eret = er; ext_irq = irq;
    model_step();
    #1;
    check_value("sb_comb_depth", comb_q.size(), 1);
    if (comb_q.size() > 0) begin
      ce = comb_q.pop_front();
      check_value("pc_en", pc_en, ce.pc_en);
      check_value("pc_in", pc_in, ce.pc_in);
    end
    @(posedge clk);
    #1;
    if (reg_q.size() > 0) begin
      re = reg_q.pop_front();
      check_value("epc", epc, re.epc);
      check_value("cause", cause, re.cause);
      check_value("in_exc", in_exc, re.in_exc);
      check_value("irq_ack", irq_ack, re.irq_ack);
      check_value("exc_count", exc_count, re.cnt);
    end else begin
      check_value("sb_reg_depth", reg_q.size(), 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_epc"}, epc, 16'h0000);
    check_value({tag, "_cause"}, cause, 4'd0);
    check_value({tag, "_in_exc"}, in_exc, 1'b0);
    check_value({tag, "_irq_ack"}, irq_ack, 1'b0);
    check_value({tag, "_exc_count"}, exc_count, 8'h00);
  endtask

  initial begin
    rst = 1'b0;
    pc_cur = 16'h0000; pc_seq = 16'h0000;
    err_imisalign = 1'b0; err_illegal = 1'b0; err_ovf = 1'b0; err_dmisalign = 1'b0;
    eret = 1'b0; ext_irq = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #2;
    rst = 1'b1;

    // normal flow
    cycle(16'h0010, 16'h0012, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_value("tp_idle_in_exc", in_exc, 1'b0);
    check_value("tp_idle_cause", cause, 4'd0);

    // illegal beats overflow
    cycle(16'h0040, 16'h0042, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_value("tp_prio_cause", cause, 4'd2);
    check_value("tp_prio_epc", epc, 16'h0040);
    check_value("tp_prio_in_exc", in_exc, 1'b1);
    check_value("tp_prio_cnt", exc_count, 8'd1);

    // return to epc
    cycle(16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_value("tp_eret_in_exc", in_exc, 1'b0);

    // interrupt, then hold level high through handler and return
    cycle(16'h0020, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_value("tp_irq_epc", epc, 16'h0022);
    check_value("tp_irq_cause", cause, 4'd5);
    check_value("tp_irq_ack", irq_ack, 1'b1);
    cycle(16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_value("tp_irq_ack_pulse", irq_ack, 1'b0);
    cycle(16'h0002, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(16'h0022, 16'h0024, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_value("tp_hold_no_retrigger", in_exc, 1'b0);
    check_value("tp_hold_cnt", exc_count, 8'd2);
    cycle(16'h0024, 16'h0026, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // interrupt raised in handler is deferred past the eret edge
    cycle(16'h0031, 16'h0033, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_value("tp_imis_cause", cause, 4'd1);
    cycle(16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(16'h0002, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_value("tp_defer_in_exc", in_exc, 1'b0);
    cycle(16'h0050, 16'h0052, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_value("tp_defer_cause", cause, 4'd5);
    check_value("tp_defer_epc", epc, 16'h0052);
    check_value("tp_defer_ack", irq_ack, 1'b1);

    // fault + eret in handler is a double fault
    cycle(16'h0060, 16'h0062, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_value("tp_double_cause", cause, 4'd7);
    check_value("tp_double_epc", epc, 16'h0052);
    check_value("tp_double_in_exc", in_exc, 1'b1);
    cycle(16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // random mix
    for (int i = 0; i < 60; i++) begin
      cycle(16'($urandom), 16'($urandom),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

    // saturation
    for (int i = 0; i < 300; i++) begin
      cycle(16'h0100, 16'h0102, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_value("tp_sat_cnt", exc_count, 8'hFF);
    check_value("tp_sat_cause", cause, 4'd7);

    // async reset mid-handler discards a pending interrupt
    cycle(16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(16'h0002, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_value("tp_pre_rst_in_exc", in_exc, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    ext_irq = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    cycle(16'h0070, 16'h0072, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_value("tp_rst_no_irq", in_exc, 1'b0);
    check_value("tp_rst_no_ack", irq_ack, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
